// File: rtl/alu_share_arb_if.sv
// Handshake and result bus between two requesters and the shared add/sub arbiter.
// Each requester sees valid/ready on its own request and response channel; the data bus is shared.
interface alu_share_arb_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_of;
  logic             rsp_c;
  logic [15:0]      ops0_cnt;
  logic [15:0]      ops1_cnt;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_sub, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_data, rsp_of, rsp_c, ops0_cnt, ops1_cnt
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_data, rsp_of, rsp_c, ops0_cnt, ops1_cnt
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester round-robin arbiter in front of one shared add/sub datapath.
// Handshake: a beat moves on any rising edge where valid && ready; ready never waits on the same-cycle ready of the other side.
module alu_share_arb #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_arb_if.slave    bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             of_q, of_d;
  logic             c_q, c_d;
  logic [15:0]      cnt0_q, cnt0_d;
  logic [15:0]      cnt1_q, cnt1_d;

  logic             gnt_v;
  logic             gnt_id;
  logic             ready0, ready1;
  logic             rsp0_v, rsp1_v;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry_into_msb;

  // Subtraction reuses the adder as A + ~B + 1; carry-in is the sub flag itself.
  assign b_eff          = sub_q ? ~b_q : b_q;
  assign sum            = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_q};
  assign carry_into_msb = sum[WIDTH-1] ^ a_q[WIDTH-1] ^ b_eff[WIDTH-1];

  // On a tie the requester that did not win last time gets the grant.
  assign gnt_v  = bus.req0_valid | bus.req1_valid;
  assign gnt_id = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    of_d    = of_q;
    c_d     = c_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    rsp0_v  = 1'b0;
    rsp1_v  = 1'b0;
    case (state_q)
      IDLE: begin
        ready0 = gnt_v & ~gnt_id;
        ready1 = gnt_v & gnt_id;
        if (gnt_v) begin
          id_d    = gnt_id;
          last_d  = gnt_id;
          a_d     = gnt_id ? bus.req1_a   : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b   : bus.req0_b;
          sub_d   = gnt_id ? bus.req1_sub : bus.req0_sub;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = sum[WIDTH-1:0];
        of_d    = carry_into_msb ^ sum[WIDTH];
        // Borrow is the inverted carry when subtracting.
        c_d     = sum[WIDTH] ^ sub_q;
        state_d = RESP;
      end
      RESP: begin
        rsp0_v = ~id_q;
        rsp1_v = id_q;
        if (id_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          if (!id_q && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
          if (id_q && cnt1_q != 16'hFFFF)  cnt1_d = cnt1_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      of_q    <= 1'b0;
      c_q     <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      of_q    <= of_d;
      c_q     <= c_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = rsp0_v;
  assign bus.rsp1_valid = rsp1_v;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_of     = of_q;
  assign bus.rsp_c      = c_q;
  assign bus.ops0_cnt   = cnt0_q;
  assign bus.ops1_cnt   = cnt1_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboarded bench for alu_share_arb: directed corner vectors, round-robin,
// response backpressure, mid-operation reset and a short random run.
module tb_alu_share_arb;
  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb_if #(.WIDTH(W)) bus ();

  alu_share_arb #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W+2:0] exp_q[$];   // {id, of, c, data}
  int           cyc_q[$];
  int           glog[$];
  bit           seen = 1'b0;
  int           exp_cnt0 = 0;
  int           exp_cnt1 = 0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour written from the arithmetic definitions, not the adder.
  function automatic logic [W+2:0] model(input logic id, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic s);
    logic [W-1:0] r;
    logic         c, of;
    if (s) begin
      r  = a - b;
      c  = (a < b);
      of = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r  = a + b;
      c  = (r < a);
      of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {id, of, c, r};
  endfunction

  // Monitor: push on request handshake, compare and pop on response.
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (!reset) begin
      if (bus.req0_valid && bus.req0_ready) begin
        exp_q.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_sub));
        cyc_q.push_back(cyc);
        glog.push_back(0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        exp_q.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_sub));
        cyc_q.push_back(cyc);
        glog.push_back(1);
      end
      chk("rsp_one_hot", bus.rsp0_valid & bus.rsp1_valid, 0);
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        chk("rsp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc - cyc_q[0], 2);
          end
          chk("rsp_id",   bus.rsp1_valid, e[W+2]);
          chk("rsp_data", bus.rsp_data, e[W-1:0]);
          chk("rsp_of",   bus.rsp_of, e[W+1]);
          chk("rsp_c",    bus.rsp_c, e[W]);
          if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            seen = 1'b0;
            if (e[W+2]) exp_cnt1++;
            else        exp_cnt0++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    exp_q.delete();
    cyc_q.delete();
    glog.delete();
    seen     = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    clear_model();
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    @(posedge clk);
    #1;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = s;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = s;
    end
    @(negedge clk);
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", n < 50, 1);
    @(posedge clk);
    #1;
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", n < 100, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts();
    chk("ops0_cnt", bus.ops0_cnt, exp_cnt0);
    chk("ops1_cnt", bus.ops1_cnt, exp_cnt1);
  endtask

  task automatic check_hold(input logic [W-1:0] d, input logic of, input logic c);
    chk("hold_data", bus.rsp_data, d);
    chk("hold_of",   bus.rsp_of, of);
    chk("hold_c",    bus.rsp_c, c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

    do_reset(2);
    chk("rst_state",  dbg_state, 0);
    chk("rst_rsp0_v", bus.rsp0_valid, 0);
    chk("rst_rsp1_v", bus.rsp1_valid, 0);
    chk("rst_ready",  {bus.req0_ready, bus.req1_ready}, 0);
    check_hold('0, 1'b0, 1'b0);
    check_cnts();

    // Directed arithmetic corners.
    send(1'b0, 64'd5, 64'd3, 1'b0);
    wait_idle();
    check_hold(64'd8, 1'b0, 1'b0);
    chk("ops0_first", bus.ops0_cnt, 1);
    send(1'b1, 64'd0, 64'd1, 1'b1);
    wait_idle();
    check_hold(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    send(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    wait_idle();
    check_hold(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_idle();
    check_hold(64'd0, 1'b0, 1'b1);
    send(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_idle();
    check_hold(64'h8000_0000_0000_0000, 1'b1, 1'b0);
    check_cnts();

    // Random operations with random response stalls.
    for (int i = 0; i < 16; i++) begin
      bit           id;
      logic [W-1:0] a, b;
      int           stall;
      id    = 1'($urandom_range(0, 1));
      a     = {$urandom, $urandom};
      b     = (i % 4 == 0) ? a : {$urandom, $urandom};
      stall = $urandom_range(0, 4);
      if (id) bus.rsp1_ready = (stall == 0);
      else    bus.rsp0_ready = (stall == 0);
      send(id, a, b, 1'($urandom_range(0, 1)));
      repeat (stall) @(posedge clk);
      #1;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      wait_idle();
      check_cnts();
    end

    // Round-robin with both requesters always valid.
    do_reset(1);
    bus.req0_a = 64'd10; bus.req0_b = 64'd1; bus.req0_sub = 1'b0;
    bus.req1_a = 64'd20; bus.req1_b = 64'd2; bus.req1_sub = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    n = 0;
    while (glog.size() < 4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_four_grants", n < 100, 1);
    for (int i = 0; i < glog.size() && i < 4; i++) chk("rr_order", glog[i], i % 2);
    wait_idle();
    chk("rr_ops0", bus.ops0_cnt, 2);
    chk("rr_ops1", bus.ops1_cnt, 2);

    // Backpressure on requester 0 while requester 1 waits.
    bus.rsp0_ready = 1'b0;
    send(1'b0, 64'd10, 64'd4, 1'b1);
    bus.req1_a = 64'd7; bus.req1_b = 64'd9; bus.req1_sub = 1'b0;
    bus.req1_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", bus.rsp0_valid, 1);
      chk("bp_data",       bus.rsp_data, 64'd6);
      chk("bp_req1_ready", bus.req1_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_state_idle", dbg_state, 0);
    chk("bp_req1_grant", bus.req1_ready, 1);
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    wait_idle();
    check_hold(64'd16, 1'b0, 1'b0);
    check_cnts();

    // Reset while an operation sits in EXEC.
    send(1'b0, 64'd100, 64'd1, 1'b0);
    chk("mid_in_exec", dbg_state, 1);
    do_reset(1);
    chk("mid_state",  dbg_state, 0);
    chk("mid_rsp0_v", bus.rsp0_valid, 0);
    check_hold('0, 1'b0, 1'b0);
    check_cnts();
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_rsp", bus.ops0_cnt, 0);
    send(1'b0, 64'd20, 64'd22, 1'b0);
    wait_idle();
    check_hold(64'd42, 1'b0, 1'b0);
    chk("mid_ops0", bus.ops0_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
